return_address_stack: RTL
=========================

# return_address_stack

Speculative return address stack (RAS) for the fetch stage. It sits beside the branch predictor and consumes its call and return classification for the fetch currently being looked up. Calls push the fall-through address; returns pop the top entry, which fetch uses as the next PC. Each outstanding fetch records a checkpoint of the stack pointer, so a branch flush discards all speculative stack updates from in-flight fetches.

## Interface
Parameters:
- RAS_DEPTH, 8: number of stack entries; must be a power of two, at least 2.
- RAS_CHECKPOINTS, 4: maximum number of outstanding fetches tracked; must be a power of two, at least 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- push  in  1  the current fetch is a predicted call (bp.is_call & bp.use_prediction).
- push_addr  in  32  return address to push (call PC + 4).
- pop  in  1  the current fetch is a predicted return (bp.is_return & bp.use_prediction).
- pop_addr  out  32  current top of stack.
- pop_valid  out  1  stack holds at least one entry.
- fetch_valid  in  1  a fetch is issued this cycle; its push and pop are qualified by this signal.
- fetch_retire  in  1  the oldest outstanding fetch has left fetch without a flush.
- branch_flush  in  1  restore stack state and drop all checkpoints.
- checkpoint_full  out  1  RAS_CHECKPOINTS fetches are outstanding; fetch must stall.

## Operation
- State:
  - stack memory: RAS_DEPTH × 32.
  - read_index: log2(RAS_DEPTH) bits; points at the top entry.
  - count: 0..RAS_DEPTH, saturating.
  - checkpoint FIFO: RAS_CHECKPOINTS entries of {read_index, count}.
- Reset: read_index=0, count=0, FIFO empty. Therefore pop_valid=0 and checkpoint_full=0. pop_addr is don't-care (the memory is not reset).
- pop_addr = mem[read_index]. pop_valid = (count != 0).
- A push or pop is effective only when fetch_valid=1 and branch_flush=0.
- Push only:
  - mem[read_index+1] ← push_addr (modulo RAS_DEPTH); read_index increments.
  - count saturates at RAS_DEPTH. When full, the oldest entry is silently overwritten (wrap-around).
- Pop only:
  - If count>0: read_index decrements (modulo RAS_DEPTH) and count decrements.
  - If count=0: no state change.
- Push and pop in the same cycle: mem[read_index] ← push_addr; read_index and count are unchanged (replace top).
- Checkpoint: on an effective fetch_valid, the pre-update {read_index, count} is written to the FIFO tail.
- fetch_retire pops the FIFO head. Retire with an empty FIFO is ignored.
- fetch_valid and fetch_retire in the same cycle: both apply, including when the FIFO is full.
- fetch_valid while the FIFO is full and fetch_retire=0 is a protocol violation. The checkpoint is dropped; the stack update still applies. The bench asserts this never happens.
- branch_flush:
  - If the FIFO is non-empty: {read_index, count} ← FIFO head.
  - If the FIFO is empty: state is unchanged.
  - The FIFO is cleared.
  - branch_flush has priority over fetch_valid, fetch_retire, push and pop in the same cycle.
- Stack memory contents are never restored. Entries overwritten by wrong-path pushes remain corrupted (accepted accuracy loss).

## Timing
- pop_addr and pop_valid are combinational from registered state (asynchronous-read LUT RAM). They are valid in the same cycle as the branch predictor's hit outputs.
- All updates are visible in the cycle after the triggering edge:
  - a pop at edge N makes the new top visible after N;
  - a push at edge N makes push_addr visible on pop_addr after N.
- checkpoint_full is registered-state derived (FIFO count = RAS_CHECKPOINTS) and has zero added latency.
- Flush restoration takes one cycle; the restored top appears in the cycle after the branch_flush edge.
- rst asserted mid-operation overrides everything on that edge and returns the block to its reset state.

## Structure
- RAS_DEPTH and RAS_CHECKPOINTS defaults go in taiga_config alongside the branch table parameters.
- ras_checkpoint_t {read_index, count} goes in taiga_types.
- One sub-module, ras_checkpoint_fifo. It is a parameterized synchronous FIFO with push, pop, clear, full and empty, and its data output shows the head entry without a read cycle.
- The stack memory is inferred in the top module.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 on three consecutive fetches -> pop_addr=0x300, pop_valid=1. Then three pops -> 0x200, 0x100, then pop_valid=0.
- With RAS_DEPTH=8, push 0x1000..0x1090 (10 pushes) -> count stays 8. Popping walks 0x1090 down to 0x1020; the ninth pop sees pop_valid=0.
- Stack [0x40, 0x80], push 0xC0 and pop together -> top=0xC0, count=2. Next pop -> 0x40.
- Stack [0x40] with one retired fetch, then fetches pushing 0x50 and 0x60 and popping 0x60 -> top=0x50. branch_flush -> top=0x40, count=1, checkpoint FIFO empty.
- Four fetches with no retire -> checkpoint_full=1. Fetch + retire in the same cycle -> checkpoint_full stays 1 and the oldest checkpoint is replaced correctly. Retire alone -> checkpoint_full=0.
- Pop with count=0 -> no state change. branch_flush together with push 0x77 -> push ignored and state restored. rst asserted mid-sequence -> pop_valid=0 next cycle.

Source files
------------

// File: rtl/return_address_stack_pkg.sv
// Shared defaults for the fetch-stage return address stack.
// Pure declarations: no logic, no latency, no flow control.
package return_address_stack_pkg;
   localparam int RAS_DEPTH_DEFAULT       = 8;
   localparam int RAS_CHECKPOINTS_DEFAULT = 4;
   localparam int ADDR_W                  = 32;
endpackage

// File: rtl/return_address_stack_if.sv
// Fetch/branch-predictor side bundle of the return address stack.
// master = fetch control and predictor, slave = the stack itself.
interface return_address_stack_if;
   import return_address_stack_pkg::*;

   logic              push;
   logic [ADDR_W-1:0] push_addr;
   logic              pop;
   logic [ADDR_W-1:0] pop_addr;
   logic              pop_valid;
   logic              fetch_valid;
   logic              fetch_retire;
   logic              branch_flush;
   logic              checkpoint_full;

   modport master (
      output push, push_addr, pop, fetch_valid, fetch_retire, branch_flush,
      input  pop_addr, pop_valid, checkpoint_full
   );

   modport slave (
      input  push, push_addr, pop, fetch_valid, fetch_retire, branch_flush,
      output pop_addr, pop_valid, checkpoint_full
   );
endinterface

// File: rtl/return_address_stack_ckpt_fifo.sv
// Synchronous FIFO with first-word-fall-through head; one-cycle write-to-head latency.
// Push while full is accepted only alongside a pop; clear wins over push and pop.
module ras_checkpoint_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              clear,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);
   localparam int PW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [PW:0]       level;
   logic              do_push;
   logic              do_pop;

   assign empty   = (level == '0);
   assign full    = (level == (PW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         level <= level + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !clear && do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/return_address_stack.sv
// Speculative return address stack: top of stack is combinational from state, updates visible next cycle.
// One pointer checkpoint per outstanding fetch; checkpoint_full tells fetch to stall, flush restores the oldest.
module return_address_stack
   import return_address_stack_pkg::*;
#(
   parameter int RAS_DEPTH       = RAS_DEPTH_DEFAULT,
   parameter int RAS_CHECKPOINTS = RAS_CHECKPOINTS_DEFAULT
) (
   input logic                   clk,
   input logic                   rst,
   return_address_stack_if.slave ras
);
   localparam int IW = $clog2(RAS_DEPTH);
   localparam int CW = IW + 1;

   typedef struct packed {
      logic [IW-1:0] read_index;
      logic [CW-1:0] count;
   } ras_checkpoint_t;

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   ras_checkpoint_t   cur;
   ras_checkpoint_t   restore;
   logic              effective;
   logic              do_push;
   logic              do_pop;
   logic              ckpt_empty;
   logic              ckpt_full;
   logic [IW-1:0]     wr_index;

   assign effective = ras.fetch_valid & ~ras.branch_flush;
   assign do_push   = effective & ras.push;
   assign do_pop    = effective & ras.pop;
   // Call+return in one fetch replaces the top rather than moving the pointer.
   assign wr_index  = do_pop ? cur.read_index : cur.read_index + IW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         cur.read_index <= '0;
         cur.count      <= '0;
      end else if (ras.branch_flush) begin
         if (!ckpt_empty) cur <= restore;
      end else if (do_push && !do_pop) begin
         cur.read_index <= cur.read_index + IW'(1);
         if (cur.count != CW'(RAS_DEPTH)) cur.count <= cur.count + CW'(1);
      end else if (do_pop && !do_push && cur.count != '0) begin
         cur.read_index <= cur.read_index - IW'(1);
         cur.count      <= cur.count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_index] <= ras.push_addr;
   end

   ras_checkpoint_fifo #(
      .DEPTH  (RAS_CHECKPOINTS),
      .DATA_W ($bits(ras_checkpoint_t))
   ) u_ckpt_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (effective),
      .push_data (cur),
      .pop       (ras.fetch_retire & ~ras.branch_flush),
      .clear     (ras.branch_flush),
      .head      (restore),
      .full      (ckpt_full),
      .empty     (ckpt_empty)
   );

   assign ras.pop_addr        = mem[cur.read_index];
   assign ras.pop_valid       = (cur.count != '0);
   assign ras.checkpoint_full = ckpt_full;
endmodule
